// File: rtl/bus_mailbox.sv
// Mailbox bus responder: DATA pushes/pops an internal FIFO; STATUS/CTRL/THRESH registers plus a level interrupt.
// Optional PEEK register at offset 0x10 when BUS_MAILBOX_PEEK_EN is defined.
module bus_mailbox #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter int Depth        = 8
) (
  input  logic                    clk_in,
  input  logic                    reset_n_in,
  input  logic                    req_in,
  input  logic [AddressWidth-1:0] addr_in,
  input  logic                    we_in,
  input  logic [DataWidth-1:0]    wdata_in,
  output logic [DataWidth-1:0]    rdata_out,
  output logic                    irq_out
);

  localparam int PtrWidth   = $clog2(Depth);
  localparam int CountWidth = $clog2(Depth) + 1;

  logic [DataWidth-1:0]  mem [Depth];
  logic [PtrWidth-1:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CountWidth-1:0] count, count_n, thresh, thresh_n;
  logic                  overflow, underflow, irq_en;
  logic                  overflow_n, underflow_n, irq_en_n, irq_n;
  logic [DataWidth-1:0]  rdata_n;
  logic [DataWidth-1:0]  status_word;
  logic                  empty, full, push_ok;
  logic [2:0]            sel;

  // Base matching happens upstream; only the register-select bits matter here.
  logic unused_addr;
  assign unused_addr = ^{addr_in[AddressWidth-1:5], addr_in[1:0]};

  assign sel   = addr_in[4:2];
  assign empty = (count == '0);
  assign full  = (count == CountWidth'(Depth));

  always_comb begin
    status_word                   = '0;
    status_word[0]                = empty;
    status_word[1]                = full;
    status_word[2]                = overflow;
    status_word[3]                = underflow;
    status_word[8 +: CountWidth]  = count;
  end

  always_comb begin
    wr_ptr_n    = wr_ptr;
    rd_ptr_n    = rd_ptr;
    count_n     = count;
    thresh_n    = thresh;
    overflow_n  = overflow;
    underflow_n = underflow;
    irq_en_n    = irq_en;
    rdata_n     = '0;
    push_ok     = 1'b0;
    if (req_in) begin
      if (we_in) begin
        case (sel)
          3'd0: begin
            if (full) begin
              overflow_n = 1'b1;
            end else begin
              push_ok  = 1'b1;
              wr_ptr_n = wr_ptr + 1'b1;
              count_n  = count + 1'b1;
            end
          end
          3'd2: begin
            if (wdata_in[1]) begin
              overflow_n  = 1'b0;
              underflow_n = 1'b0;
            end
            irq_en_n = wdata_in[2];
            if (wdata_in[0]) begin
              wr_ptr_n = '0;
              rd_ptr_n = '0;
              count_n  = '0;
            end
          end
          3'd3: thresh_n = wdata_in[CountWidth-1:0];
          default: ;
        endcase
      end else begin
        case (sel)
          3'd0: begin
            if (empty) begin
              underflow_n = 1'b1;
            end else begin
              rdata_n  = mem[rd_ptr];
              rd_ptr_n = rd_ptr + 1'b1;
              count_n  = count - 1'b1;
            end
          end
          3'd1: rdata_n = status_word;
          3'd2: rdata_n[2] = irq_en;
          3'd3: rdata_n[CountWidth-1:0] = thresh;
`ifdef BUS_MAILBOX_PEEK_EN
          3'd4: rdata_n = empty ? '0 : mem[rd_ptr];
`endif
          default: ;
        endcase
      end
    end
    irq_n = irq_en_n && (thresh_n != '0) && (count_n >= thresh_n);
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      thresh    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      irq_en    <= 1'b0;
      rdata_out <= '0;
      irq_out   <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      thresh    <= thresh_n;
      overflow  <= overflow_n;
      underflow <= underflow_n;
      irq_en    <= irq_en_n;
      rdata_out <= rdata_n;
      irq_out   <= irq_n;
    end
  end

  // Storage is deliberately left out of reset; flush only moves the pointers.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr] <= wdata_in;
  end

endmodule

// File: tb/tb_bus_mailbox.sv
// Directed, table-driven bench for bus_mailbox at Depth=4, plus a hand-written mid-operation reset sequence.
module tb_bus_mailbox;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req;
  logic [AW-1:0] addr;
  logic          we;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          irq;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  bus_mailbox #(
    .DataWidth   (DW),
    .AddressWidth(AW),
    .Depth       (4)
  ) dut (
    .clk_in    (clk),
    .reset_n_in(reset_n),
    .req_in    (req),
    .addr_in   (addr),
    .we_in     (we),
    .wdata_in  (wdata),
    .rdata_out (rdata),
    .irq_out   (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_irq;
  } vec_t;

  vec_t vecs [128];
  int unsigned n_vec = 0;

  localparam logic [AW-1:0] A_DATA = 32'h00, A_STAT = 32'h04, A_CTRL = 32'h08,
                            A_THR = 32'h0C, A_PEEK = 32'h10;

`ifdef BUS_MAILBOX_PEEK_EN
  localparam logic [DW-1:0] PEEK_EXP = 32'h55;
`else
  localparam logic [DW-1:0] PEEK_EXP = 32'h0;
`endif

  task automatic add(input logic r, input logic w, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [DW-1:0] er, input logic ei);
    vecs[n_vec] = '{req: r, we: w, addr: a, wdata: d, exp_rdata: er, exp_irq: ei};
    n_vec++;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic ei);
    add(1'b1, 1'b1, a, d, 32'h0, ei);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] er, input logic ei);
    add(1'b1, 1'b0, a, 32'h0, er, ei);
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Drive one bus cycle and sample the registered response just after the edge.
  task automatic access(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req = r; we = w; addr = a; wdata = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;

    // Reset state, full/overflow, in-order pops
    rd(A_STAT, 32'h0000_0001, 1'b0);
    wr(A_DATA, 32'hA1, 1'b0);
    wr(A_DATA, 32'hB2, 1'b0);
    wr(A_DATA, 32'hC3, 1'b0);
    wr(A_DATA, 32'hD4, 1'b0);
    wr(A_DATA, 32'hE5, 1'b0);
    rd(A_STAT, 32'h0000_0406, 1'b0);
    rd(A_DATA, 32'hA1, 1'b0);
    rd(A_DATA, 32'hB2, 1'b0);
    rd(A_DATA, 32'hC3, 1'b0);
    rd(A_DATA, 32'hD4, 1'b0);
    // Underflow, sticky clear
    rd(A_DATA, 32'h0, 1'b0);
    rd(A_STAT, 32'h0000_000D, 1'b0);
    wr(A_CTRL, 32'h2, 1'b0);
    rd(A_STAT, 32'h0000_0001, 1'b0);
    rd(A_CTRL, 32'h0, 1'b0);
    add(1'b0, 1'b0, A_DATA, 32'h0, 32'h0, 1'b0);
    // Wrap-around
    for (int unsigned k = 0; k < 2; k++) begin
      for (int unsigned j = 1; j <= 3; j++) wr(A_DATA, 32'(k * 3 + j), 1'b0);
      for (int unsigned j = 1; j <= 3; j++) rd(A_DATA, 32'(k * 3 + j), 1'b0);
    end
    wr(A_DATA, 32'h11, 1'b0);
    wr(A_DATA, 32'h22, 1'b0);
    rd(A_DATA, 32'h11, 1'b0);
    rd(A_DATA, 32'h22, 1'b0);
    // Threshold interrupt
    wr(A_THR, 32'h2, 1'b0);
    rd(A_THR, 32'h2, 1'b0);
    wr(A_CTRL, 32'h4, 1'b0);
    rd(A_CTRL, 32'h4, 1'b0);
    wr(A_DATA, 32'h77, 1'b0);
    wr(A_DATA, 32'h88, 1'b1);
    rd(A_STAT, 32'h0000_0200, 1'b1);
    rd(A_DATA, 32'h77, 1'b0);
    wr(A_THR, 32'h1F, 1'b0);
    rd(A_THR, 32'h7, 1'b0);
    wr(A_THR, 32'h1, 1'b1);
    wr(A_CTRL, 32'h5, 1'b0);
    rd(A_STAT, 32'h0000_0001, 1'b0);
    // Reserved space
    rd(32'h14, 32'h0, 1'b0);
    wr(32'h18, 32'hFFFF_FFFF, 1'b0);
    rd(A_STAT, 32'h0000_0001, 1'b0);
    // Peek
    wr(A_DATA, 32'h55, 1'b1);
    rd(A_PEEK, PEEK_EXP, 1'b1);
    rd(A_PEEK, PEEK_EXP, 1'b1);
    rd(A_STAT, 32'h0000_0100, 1'b1);
    rd(A_DATA, 32'h55, 1'b0);
    // Threshold beyond depth never fires
    wr(A_THR, 32'h5, 1'b0);
    for (int unsigned j = 0; j < 4; j++) wr(A_DATA, 32'h60 + 32'(j), 1'b0);
    rd(A_STAT, 32'h0000_0402, 1'b0);
    wr(A_CTRL, 32'h5, 1'b0);
    rd(A_STAT, 32'h0000_0001, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);

    for (int unsigned i = 0; i < n_vec; i++) begin
      access(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
    end

    // Mid-operation asynchronous reset with a read in flight
    access(1'b1, 1'b1, A_THR, 32'h1);
    access(1'b1, 1'b1, A_DATA, 32'h99);
    check("pre_rst_irq", {31'b0, irq}, 32'h1);
    access(1'b1, 1'b0, A_STAT, 32'h0);
    check("pre_rst_status", rdata, 32'h0000_0100);
    req = 1'b1; we = 1'b0; addr = A_DATA;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_rdata", rdata, 32'h0);
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check("inflight_rdata", rdata, 32'h0);
    req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    access(1'b1, 1'b0, A_STAT, 32'h0);
    check("post_rst_status", rdata, 32'h0000_0001);
    access(1'b1, 1'b0, A_THR, 32'h0);
    check("post_rst_thresh", rdata, 32'h0);
    access(1'b1, 1'b0, A_CTRL, 32'h0);
    check("post_rst_ctrl", rdata, 32'h0);
    access(1'b1, 1'b0, A_DATA, 32'h0);
    check("post_rst_pop", rdata, 32'h0);
    check("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_mailbox.md
Name: bus_mailbox

Overview:
- Bus responder (device end) for the shared host/device bus: one device port of the interconnect lands here.
- Hosts push words into an internal FIFO by writing DATA, and pop words by reading DATA.
- Status, control, threshold and interrupt registers let hosts pass messages to each other through this device.
- Always accepts requests: there is no grant or ready on the device side. Read data is returned exactly 1 cycle after the request.

Parameters:
- DataWidth, 32, bus data width; must be at least 16.
- AddressWidth, 32, bus address width; only addr_in[4:2] is decoded, because base matching is done upstream.
- Depth, 8, FIFO depth in words; must be a power of 2, from 2 to 128.
- CountWidth (localparam), clog2(Depth)+1, width of the occupancy count.

Ports:
- clk_in  input  1  clock; all state changes on the rising edge.
- reset_n_in  input  1  asynchronous, active-low reset.
- req_in  input  1  request valid this cycle.
- addr_in  input  AddressWidth  byte address; bits [4:2] select the register.
- we_in  input  1  1 = write, 0 = read; sampled only when req_in=1.
- wdata_in  input  DataWidth  write data.
- rdata_out  output  DataWidth  registered read data, valid the cycle after a read request.
- irq_out  output  1  registered level interrupt.

Behaviour:
- Register map (offset = addr_in[4:2]*4):
  - 0x00 DATA: write pushes wdata_in; read pops the head.
  - 0x04 STATUS (RO):
    - [0] empty
    - [1] full
    - [2] overflow (sticky)
    - [3] underflow (sticky)
    - [15:8] count, zero-extended
    - other bits read 0
  - 0x08 CTRL:
    - write: [0] flush (self-clearing); [1] clear both sticky flags (self-clearing); [2] irq_en (stored)
    - read: returns irq_en in bit 2, other bits 0
  - 0x0C THRESH (RW): bits [CountWidth-1:0] stored; other bits ignored on write and read 0.
  - 0x10–0x1C: reserved. Reads return 0; writes are ignored.
- Reset (async assert, sync release):
  - FIFO empty, count=0, pointers=0
  - overflow=0, underflow=0, irq_en=0, THRESH=0
  - rdata_out=0, irq_out=0
- Read latency:
  - Read request in cycle N → rdata_out holds the value in cycle N+1.
  - Any cycle with no read request → rdata_out is 0 in the next cycle.
  - A write never changes rdata_out except forcing it to 0.
- DATA read (pop):
  - Not empty: rdata_out gets mem[rd_ptr]; rd_ptr increments and count decrements at the same edge.
  - Empty: rdata_out=0, underflow is set, pointers are unchanged.
- DATA write (push):
  - Not full: mem[wr_ptr] gets wdata_in; wr_ptr increments and count increments.
  - Full: data is dropped, overflow is set, and no state changes.
- Pointers are clog2(Depth) bits wide and wrap naturally Depth-1 → 0. Count saturates logically, because full or empty blocks further push or pop.
- Simultaneous push and pop is impossible: the bus is single-port with one request per cycle.
- STATUS read returns the pre-edge state of cycle N, i.e. not including that request's own effect.
- CTRL write:
  - Flush has priority. It zeroes the pointers and count and takes effect at that edge; memory contents are not cleared.
  - Clearing the sticky flags and writing irq_en happen in the same write.
- irq_out, registered from next-state values, is 1 when all of:
  - irq_en=1
  - THRESH≠0
  - count ≥ THRESH

  irq_out updates the edge after the causing access, and drops the cycle after the condition clears.
- THRESH > Depth is legal; irq_out then never asserts.
- Reset asserted mid-operation: all state clears immediately and asynchronously; an in-flight read returns 0.

Optional Feature:
- Macro: BUS_MAILBOX_PEEK_EN.
- Defined: offset 0x10 is PEEK (RO).
  - Read returns mem[rd_ptr] with the same 1-cycle latency and no pop.
  - Empty: returns 0 without setting underflow.
  - Writes to 0x10 are ignored.
- Undefined: 0x10 is reserved like 0x14–0x1C, with no extra logic.

Test Plan:
- Depth=4. After reset, read STATUS → rdata_out=0x0000_0001 in the next cycle; irq_out=0.
- Push 0xA1, 0xB2, 0xC3, 0xD4, then a 5th push of 0xE5 → STATUS reads 0x0000_0406 (count 4, full, overflow). Four pops then return 0xA1, 0xB2, 0xC3, 0xD4; 0xE5 never appears.
- Pop from empty → rdata_out=0 and STATUS bit 3 set. CTRL write 0x2 → STATUS reads 0x0000_0001.
- Wrap-around: push 3 / pop 3 twice, then push 0x11, 0x22 → pops return 0x11, 0x22 in order.
- THRESH=2, CTRL=0x4; push two words → irq_out=1 on the edge after the 2nd push. One pop → irq_out=0 the following cycle. CTRL=0x5 (flush) → count 0 and irq_out stays 0.
- With BUS_MAILBOX_PEEK_EN defined: push 0x55, read 0x10 twice → 0x55 both times, count stays 1. Without the macro, the same read returns 0.
